// File: rtl/axi_chan_demux_1xn.sv
// Registered 1-to-N AXI channel demux with a two-entry skid buffer.
// Each beat is steered to one of NUM_OUT outputs by its select.
//
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   s_valid/s_ready        input handshake (s_ready comes from a flop)
//   s_data/s_last/s_sel    input payload, last flag, destination index
//   m_valid/m_ready        per-output handshake (m_valid one-hot or zero)
//   m_data/m_last          flattened payloads (slice i = [i*WIDTH +: WIDTH])
//   sel_err                one-cycle pulse: beat with bad select dropped
//
// Optional feature: define AXI_DEMUX_BURST_LOCK_EN to lock the select
// taken from the first beat of a burst until the beat with s_last.

module axi_chan_demux_1xn #(
    parameter int WIDTH   = 32,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     s_last,
    input  logic [SEL_W-1:0]         s_sel,
    output logic [NUM_OUT-1:0]       m_valid,
    input  logic [NUM_OUT-1:0]       m_ready,
    output logic [NUM_OUT*WIDTH-1:0] m_data,
    output logic [NUM_OUT-1:0]       m_last,
    output logic                     sel_err
);

    localparam logic [SEL_W:0] NUM_OUT_C = (SEL_W+1)'(NUM_OUT);

    logic             main_v_q, main_v_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_last_q, main_last_d;
    logic [SEL_W-1:0] main_sel_q, main_sel_d;

    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_last_q, skid_last_d;
    logic [SEL_W-1:0] skid_sel_q, skid_sel_d;

    logic             s_ready_q, s_ready_d;
    logic             sel_err_q, sel_err_d;

    logic [SEL_W-1:0] eff_sel;
    logic             acc;
    logic             acc_ok;
    logic             in_range;
    logic [NUM_OUT-1:0] hit;
    logic             out_fire;

    assign acc = s_valid && s_ready_q;

`ifdef AXI_DEMUX_BURST_LOCK_EN
    logic             lock_v_q, lock_v_d;
    logic [SEL_W-1:0] lock_sel_q, lock_sel_d;

    assign eff_sel = lock_v_q ? lock_sel_q : s_sel;

    // Lock is taken on the first beat and dropped on the last one,
    // whether the beat was routed or discarded.
    always_comb begin
        lock_v_d   = lock_v_q;
        lock_sel_d = lock_sel_q;
        if (acc) begin
            if (s_last) begin
                lock_v_d = 1'b0;
            end else if (!lock_v_q) begin
                lock_v_d   = 1'b1;
                lock_sel_d = s_sel;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            lock_v_q   <= 1'b0;
            lock_sel_q <= '0;
        end else begin
            lock_v_q   <= lock_v_d;
            lock_sel_q <= lock_sel_d;
        end
    end
`else
    assign eff_sel = s_sel;
`endif

    assign in_range = ({1'b0, eff_sel} < NUM_OUT_C);
    assign acc_ok   = acc && in_range;

    // Main only ever holds in-range selects, so hit is one-hot or zero.
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            hit[i] = main_v_q && (main_sel_q == SEL_W'(i));
        end
    end

    assign out_fire = |(hit & m_ready);

    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            m_data[i*WIDTH +: WIDTH] = hit[i] ? main_data_q : '0;
            m_last[i]                = hit[i] && main_last_q;
        end
    end

    assign m_valid = hit;
    assign s_ready = s_ready_q;
    assign sel_err = sel_err_q;

    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_last_d = main_last_q;
        main_sel_d  = main_sel_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        skid_sel_d  = skid_sel_q;
        if (!main_v_q || out_fire) begin
            if (skid_v_q) begin
                main_v_d    = 1'b1;
                main_data_d = skid_data_q;
                main_last_d = skid_last_q;
                main_sel_d  = skid_sel_q;
                skid_v_d    = acc_ok;
                skid_data_d = s_data;
                skid_last_d = s_last;
                skid_sel_d  = eff_sel;
            end else begin
                main_v_d    = acc_ok;
                main_data_d = s_data;
                main_last_d = s_last;
                main_sel_d  = eff_sel;
            end
        end else if (acc_ok) begin
            // s_ready is only high with an empty skid, so no overwrite.
            skid_v_d    = 1'b1;
            skid_data_d = s_data;
            skid_last_d = s_last;
            skid_sel_d  = eff_sel;
        end
        s_ready_d = !skid_v_d;
        sel_err_d = acc && !in_range;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            main_last_q <= 1'b0;
            main_sel_q  <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            skid_sel_q  <= '0;
            s_ready_q   <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_last_q <= main_last_d;
            main_sel_q  <= main_sel_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            skid_sel_q  <= skid_sel_d;
            s_ready_q   <= s_ready_d;
            sel_err_q   <= sel_err_d;
        end
    end

endmodule

// File: tb/tb_axi_chan_demux_1xn.sv
// Testbench for axi_chan_demux_1xn: table-driven vectors on a 4-output
// instance plus hand sequences for reset, bad selects and a 3-output instance.

module tb_axi_chan_demux_1xn;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         s_valid, s_ready, s_last, sel_err;
    logic [31:0]  s_data;
    logic [1:0]   s_sel;
    logic [3:0]   m_valid, m_ready, m_last;
    logic [127:0] m_data;

    logic         t_valid, t_ready, t_last, t_err;
    logic [31:0]  t_data;
    logic [1:0]   t_sel;
    logic [2:0]   t_mvalid, t_mready, t_mlast;
    logic [95:0]  t_mdata;

    axi_chan_demux_1xn #(.WIDTH(32), .NUM_OUT(4)) dut4 (
        .ACLK(clk), .ARESETN(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_sel(s_sel),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .sel_err(sel_err)
    );

    axi_chan_demux_1xn #(.WIDTH(32), .NUM_OUT(3)) dut3 (
        .ACLK(clk), .ARESETN(rst_n),
        .s_valid(t_valid), .s_ready(t_ready), .s_data(t_data),
        .s_last(t_last), .s_sel(t_sel),
        .m_valid(t_mvalid), .m_ready(t_mready), .m_data(t_mdata),
        .m_last(t_mlast), .sel_err(t_err)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic        vld;
        logic [1:0]  sel;
        logic [31:0] d;
        logic        last;
        logic [3:0]  mrdy;
        logic        on;
        logic [1:0]  esel;
        logic [31:0] ed;
        logic        elast;
        logic        erdy;
    } vec_t;

    vec_t tv[$];

    function automatic void addv(logic vld, logic [1:0] sel, logic [31:0] d,
                                 logic last, logic [3:0] mrdy, logic on,
                                 logic [1:0] esel, logic [31:0] ed,
                                 logic elast, logic erdy);
        vec_t v;
        v.vld = vld; v.sel = sel; v.d = d; v.last = last; v.mrdy = mrdy;
        v.on = on; v.esel = esel; v.ed = ed; v.elast = elast; v.erdy = erdy;
        tv.push_back(v);
    endfunction

    logic [1:0] bsel [6];
    logic [1:0] lsel [6];
    logic [31:0] bdat [6];
    logic        blst [6];

    initial begin
        logic [3:0]   emv;
        logic [127:0] emd;
        logic [3:0]   eml;

        // streaming, sel cycling 0..3, all ready
        for (int i = 0; i < 8; i++)
            addv(1, 2'(i % 4), 32'h10 + 32'(i), 0, 4'hf,
                 1, 2'(i % 4), 32'h10 + 32'(i), 0, 1);
        addv(0, 0, 0, 0, 4'hf, 0, 0, 0, 0, 1);
        // backpressure on output 2
        addv(1, 2, 32'h20, 0, 4'b1011, 1, 2, 32'h20, 0, 1);
        addv(1, 2, 32'h21, 0, 4'b1011, 1, 2, 32'h20, 0, 0);
        addv(1, 2, 32'h22, 0, 4'b1011, 1, 2, 32'h20, 0, 0);
        addv(1, 2, 32'h22, 0, 4'hf,    1, 2, 32'h21, 0, 1);
        addv(1, 2, 32'h22, 0, 4'hf,    1, 2, 32'h22, 0, 1);
        addv(0, 0, 0,      0, 4'hf,    0, 0, 0,      0, 1);
        // two bursts: 4 beats then 2 beats
        bsel = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd0};
        bdat = '{32'h50, 32'h51, 32'h52, 32'h53, 32'h60, 32'h61};
        blst = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef AXI_DEMUX_BURST_LOCK_EN
        lsel = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
`else
        lsel = bsel;
`endif
        for (int i = 0; i < 6; i++)
            addv(1, bsel[i], bdat[i], blst[i], 4'hf,
                 1, lsel[i], bdat[i], blst[i], 1);
        addv(0, 0, 0, 0, 4'hf, 0, 0, 0, 0, 1);

        rst_n = 1'b0;
        s_valid = 1'b1; s_sel = 0; s_data = 32'h99; s_last = 0;
        m_ready = 4'hf;
        t_valid = 0; t_sel = 0; t_data = 0; t_last = 0; t_mready = 3'b111;

        // reset behaviour and release
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_t_ready", t_ready, 0);
        rst_n = 1'b1;
        #1 chk("rel_s_ready_low", s_ready, 0);
        @(negedge clk);
        chk("rel_s_ready_high", s_ready, 1);
        chk("rel_m_valid", m_valid, 0);
        s_valid = 1'b0;

        // table vectors
        foreach (tv[i]) begin
            s_valid = tv[i].vld; s_sel = tv[i].sel; s_data = tv[i].d;
            s_last = tv[i].last; m_ready = tv[i].mrdy;
            @(posedge clk);
            @(negedge clk);
            emv = tv[i].on ? 4'(1 << tv[i].esel) : 4'd0;
            emd = tv[i].on ? (128'(tv[i].ed) << (32 * tv[i].esel)) : 128'd0;
            eml = (tv[i].on && tv[i].elast) ? 4'(1 << tv[i].esel) : 4'd0;
            chk($sformatf("v%0d_m_valid", i), m_valid, emv);
            chk($sformatf("v%0d_m_data", i), m_data, emd);
            chk($sformatf("v%0d_m_last", i), m_last, eml);
            chk($sformatf("v%0d_s_ready", i), s_ready, tv[i].erdy);
            chk($sformatf("v%0d_sel_err", i), sel_err, 0);
        end
        s_valid = 0;

        // NUM_OUT=3: out-of-range selects are dropped with one pulse each
        t_valid = 1; t_sel = 3; t_data = 32'h33;
        @(posedge clk); @(negedge clk);
        chk("bad1_err", t_err, 1);
        chk("bad1_mvalid", t_mvalid, 0);
        chk("bad1_ready", t_ready, 1);
        t_data = 32'h34;
        @(posedge clk); @(negedge clk);
        chk("bad2_err", t_err, 1);
        chk("bad2_mvalid", t_mvalid, 0);
        t_sel = 1; t_data = 32'h44;
        @(posedge clk); @(negedge clk);
        chk("good_err", t_err, 0);
        chk("good_mvalid", t_mvalid, 3'b010);
        chk("good_mdata", t_mdata, 96'h44 << 32);
        t_valid = 0;
        @(posedge clk); @(negedge clk);
        chk("idle_err", t_err, 0);
        chk("idle_mvalid", t_mvalid, 0);

        // reset with two beats buffered
        m_ready = 4'h0;
        s_valid = 1; s_sel = 0; s_data = 32'h70; s_last = 0;
        @(posedge clk); @(negedge clk);
        s_data = 32'h71;
        @(posedge clk); @(negedge clk);
        chk("buf_s_ready", s_ready, 0);
        chk("buf_m_valid", m_valid, 4'b0001);
        chk("buf_m_data", m_data, 128'h70);
        s_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 4'hf;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_m_valid", i), m_valid, 0);
        end
        chk("post_rst_s_ready", s_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/axi_chan_demux_1xn.md
# axi_chan_demux_1xn

Registered 1-to-N demultiplexer for a single AXI valid/ready channel. It sits in the interconnect datapath between a master-side channel and N slave-side channels. Each beat is steered by a per-beat select. A two-entry skid buffer gives full throughput with a registered `s_ready`, and out-of-range selects are flagged. It generalises the combinational 1x2 demux to N outputs with handshake, buffering and optional burst locking.

## Interface
- `WIDTH`, 32: payload bits per beat.
- `NUM_OUT`, 4: number of output channels, 2..16.
- `SEL_W`, `$clog2(NUM_OUT)`: select width. Must be ≥1.
- `ACLK`  in  1  clock; all logic on the rising edge.
- `ARESETN`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input ready, driven straight from a flop.
- `s_data`  in  WIDTH  input payload.
- `s_last`  in  1  last beat of burst.
- `s_sel`  in  SEL_W  destination index.
- `m_valid`  out  NUM_OUT  per-output valid, one-hot or zero.
- `m_ready`  in  NUM_OUT  per-output ready.
- `m_data`  out  NUM_OUT*WIDTH  flattened payloads; slice i is `[i*WIDTH +: WIDTH]`.
- `m_last`  out  NUM_OUT  per-output last.
- `sel_err`  out  1  one-cycle pulse: a beat with an out-of-range select was accepted and dropped.

## Operation
- Storage is two entries:
  - Main register (`main_v`, data, last, sel) drives the outputs.
  - Skid register (`skid_v`, same fields) holds one extra beat.
- Input handshake: a beat is accepted when `s_valid && s_ready`.
- Effective select:
  - `eff_sel` is `s_sel`, or the locked select (see Configuration).
  - If `eff_sel >= NUM_OUT`, the accepted beat is discarded. It is not stored. `sel_err` is 1 on the next cycle.
- Output: when `main_v` is set, `m_valid[main_sel]` = 1 and all other bits are 0.
  - `m_data` slice `main_sel` = main payload. All other slices are 0.
  - `m_last` follows the same rule.
  - With `main_v` = 0, all `m_*` outputs are 0.
- Output handshake: `out_fire` = `main_v && m_ready[main_sel]`. Readiness of non-selected outputs is ignored.
- Per-cycle update, given a valid in-range accepted beat `acc`:
  - Main empty or `out_fire`, skid empty: main loads `acc` if present, else main clears.
  - Main empty or `out_fire`, skid full: main loads skid. Skid loads `acc` if present, else skid clears.
  - Main full, no `out_fire`: `acc`, if present, goes into skid.
- `s_ready` next = NOT (skid valid next). It deasserts the cycle after the skid fills.
- Beats leave in acceptance order. Routing never reorders or duplicates beats.

## Timing
- Reset values while `ARESETN` is low: `s_ready` = 0, all `m_valid`, `m_data`, `m_last` = 0, `sel_err` = 0, both entries invalid, lock cleared.
- `s_ready` rises on the first `ACLK` edge after `ARESETN` deasserts.
- Latency: a beat accepted at edge k appears on `m_*` after edge k (1 cycle) if main is empty or firing at edge k.
- Throughput: one beat per cycle sustained while the selected `m_ready` is high.
- Backpressure: with the selected `m_ready` low, the block absorbs exactly 2 beats, then `s_ready` = 0.
- Simultaneous accept and `out_fire` with skid empty: main is replaced and `s_ready` stays 1.
- Reset mid-operation: buffered beats are lost and all outputs clear asynchronously.
- `sel_err` is registered and never high for two cycles from one beat. Back-to-back bad beats give consecutive pulses.

## Configuration
- `AXI_DEMUX_BURST_LOCK_EN`, defined:
  - On an accepted first beat (lock clear), `s_sel` is captured into `lock_sel` and lock is set.
  - Every following beat uses `lock_sel` and ignores `s_sel`.
  - An accepted beat with `s_last` = 1 clears the lock after it is routed or dropped.
  - An out-of-range locked select drops the whole burst, with one `sel_err` pulse per beat.
- `AXI_DEMUX_BURST_LOCK_EN`, undefined: no lock state. `eff_sel` = `s_sel` for every beat, and `s_last` is only forwarded.

## Test plan
- Reset release, `NUM_OUT`=4, `s_valid` held 1 → `s_ready` low until the first edge after release, then 1. All `m_valid` = 0 during reset.
- Stream 8 beats, data 0x10..0x17, `s_sel` cycling 0,1,2,3, all `m_ready` = 1 → each beat appears 1 cycle later on `m_valid` bit sel with the matching slice. Other slices are 0. No bubbles.
- `m_ready[2]` = 0, send 3 beats with sel 2 → first beat held on main, second in skid, `s_ready` = 0, third stalls. Raise `m_ready[2]` → beats 0,1,2 drain in order on consecutive cycles.
- `NUM_OUT`=3, beat with sel 3 → accepted, no `m_valid`, `sel_err` = 1 for exactly one cycle. The next beat with sel 1 routes normally.
- With the macro defined, a 4-beat burst with sel 1 on the first beat and sel 0/2/3 on later beats, last on beat 4 → all 4 beats on output 1. The next burst uses its own first-beat sel. Without the macro the same stimulus routes per beat.
- Pulse `ARESETN` low with 2 beats buffered → all outputs 0 immediately. After release, no stale beat is emitted.
